// File: rtl/fu_sched_if.sv
// fu_sched_if: issue-side bundle between the issue stage (master) and the
// function-unit scheduler (slave).
//   redir       master->slave  pipeline redirect / flush
//   lsu_ready   master->slave  LSU can take an op this cycle
//   iss_bundle  master->slave  iwd issued ops (valid = opid[15], class mask = fu, dest = prda)
//   issue       slave->master  per-lane acceptance, combinational, always a prefix
//   fu_ready    slave->master  per-class availability {DIV,MUL,LSU,BR,ALU}
//   ex_bundle   slave->master  ewd registered execute lanes (ALU..., BR, LSU, MD)
//   md_wb_*     slave->master  mul/div completion wakeup
interface fu_sched_if #(
   parameter int iwd = 4,
   parameter int ewd = 4
);
   typedef struct packed {
      logic [15:0] opid;
      logic [4:0]  fu;
      logic [15:0] prda;
   } iss_bundle_t;

   logic           redir;
   logic           lsu_ready;
   iss_bundle_t    iss_bundle [iwd];
   logic [iwd-1:0] issue;
   logic [4:0]     fu_ready;
   iss_bundle_t    ex_bundle [ewd];
   logic           md_wb_valid;
   logic [15:0]    md_wb_prd;
   logic [15:0]    md_wb_opid;

   modport master (
      output redir, lsu_ready, iss_bundle,
      input  issue, fu_ready, ex_bundle, md_wb_valid, md_wb_prd, md_wb_opid
   );

   modport slave (
      input  redir, lsu_ready, iss_bundle,
      output issue, fu_ready, ex_bundle, md_wb_valid, md_wb_prd, md_wb_opid
   );
endinterface

// File: rtl/fu_sched.sv
// fu_sched: accepts up to iwd issued ops per cycle against function-unit
// availability, routes accepted ops onto registered execute lanes, and tracks
// the pipelined multiplier and iterative divider to broadcast their completion.
//   clk   in  clock
//   rst   in  synchronous active-high reset
//   bus   fu_sched_if.slave (see interface header for signal list)
//
// Divider states:
//   state   | meaning
//   st_idle | no divide in flight; MUL and DIV may be accepted
//   st_busy | divide iterating, div_cnt counts down to 0
//   st_done | result cycle: md_wb carries the latched divide dest/opid
module fu_sched #(
   parameter int iwd     = 4,
   parameter int alu_n   = 1,
   parameter int mul_lat = 3,
   parameter int div_lat = 16
) (
   input logic       clk,
   input logic       rst,
   fu_sched_if.slave bus
);
   localparam int ewd   = alu_n + 3;
   localparam int br_l  = alu_n;
   localparam int lsu_l = alu_n + 1;
   localparam int md_l  = alu_n + 2;
   localparam int cw    = $clog2(div_lat) + 1;
   localparam int aw    = $clog2(alu_n) + 1;

   localparam logic [1:0] st_idle = 2'd0;
   localparam logic [1:0] st_busy = 2'd1;
   localparam logic [1:0] st_done = 2'd2;

   typedef struct packed {
      logic [15:0] opid;
      logic [4:0]  fu;
      logic [15:0] prda;
   } iss_bundle_t;

   logic [1:0]         div_st;
   logic [cw-1:0]      div_cnt;
   logic [15:0]        div_prd, div_opid;
   logic [mul_lat-1:0] mul_v;
   logic [15:0]        mul_prd  [mul_lat];
   logic [15:0]        mul_opid [mul_lat];
   logic               mul_wb_v;
   logic [15:0]        mul_wb_prd, mul_wb_opid;
   logic [4:0]         rdy;
   iss_bundle_t        ex_nxt [ewd];
   logic [iwd-1:0]     acc;
   logic               mul_go, div_go;
   logic [15:0]        md_prd_in, md_opid_in;

   // DIV additionally waits for the mul pipe to drain so the two never
   // complete in the same cycle.
   assign rdy = {(div_st == st_idle) && (mul_v == '0), div_st == st_idle,
                 bus.lsu_ready, 1'b1, 1'b1};
   assign bus.fu_ready = rdy;
   assign bus.issue    = acc;

   always_comb begin
      logic [aw-1:0] alu_used;
      logic          br_b, lsu_b, md_b, scan, hit;
      logic [2:0]    cls;
      logic [4:0]    avail;
      alu_used   = '0;
      br_b       = 1'b1;
      lsu_b      = 1'b1;
      md_b       = 1'b1;
      scan       = !rst && !bus.redir;
      acc        = '0;
      mul_go     = 1'b0;
      div_go     = 1'b0;
      md_prd_in  = '0;
      md_opid_in = '0;
      hit        = 1'b0;
      cls        = '0;
      avail      = '0;
      for (int l = 0; l < ewd; l++) ex_nxt[l] = '0;
      for (int i = 0; i < iwd; i++) begin
         hit   = 1'b0;
         cls   = '0;
         avail = rdy & {md_b, md_b, lsu_b, br_b, alu_used != aw'(alu_n)};
         if (scan && bus.iss_bundle[i].opid[15]) begin
            // descending walk so the lowest eligible class wins
            for (int c = 4; c >= 0; c--) begin
               if (bus.iss_bundle[i].fu[c] && avail[c]) begin
                  hit = 1'b1;
                  cls = 3'(c);
               end
            end
         end
         // first lane that cannot go ends the scan; accepted set stays a prefix
         if (!hit) begin
            scan = 1'b0;
         end else begin
            acc[i] = 1'b1;
            case (cls)
               3'd0: begin
                  for (int a = 0; a < alu_n; a++)
                     if (alu_used == aw'(a)) ex_nxt[a] = bus.iss_bundle[i];
                  alu_used = alu_used + aw'(1);
               end
               3'd1: begin
                  ex_nxt[br_l] = bus.iss_bundle[i];
                  br_b = 1'b0;
               end
               3'd2: begin
                  ex_nxt[lsu_l] = bus.iss_bundle[i];
                  lsu_b = 1'b0;
               end
               3'd3, 3'd4: begin
                  ex_nxt[md_l] = bus.iss_bundle[i];
                  md_b       = 1'b0;
                  mul_go     = (cls == 3'd3);
                  div_go     = (cls == 3'd4);
                  md_prd_in  = bus.iss_bundle[i].prda;
                  md_opid_in = bus.iss_bundle[i].opid;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || bus.redir) begin
         for (int l = 0; l < ewd; l++) bus.ex_bundle[l] <= '0;
         mul_v <= '0;
         for (int s = 0; s < mul_lat; s++) begin
            mul_prd[s]  <= '0;
            mul_opid[s] <= '0;
         end
         mul_wb_v    <= 1'b0;
         mul_wb_prd  <= '0;
         mul_wb_opid <= '0;
         div_st      <= st_idle;
         div_cnt     <= '0;
         div_prd     <= '0;
         div_opid    <= '0;
      end else begin
         for (int l = 0; l < ewd; l++) bus.ex_bundle[l] <= ex_nxt[l];
         mul_v[0]    <= mul_go;
         mul_prd[0]  <= md_prd_in;
         mul_opid[0] <= md_opid_in;
         for (int s = 1; s < mul_lat; s++) begin
            mul_v[s]    <= mul_v[s-1];
            mul_prd[s]  <= mul_prd[s-1];
            mul_opid[s] <= mul_opid[s-1];
         end
         mul_wb_v    <= mul_v[mul_lat-1];
         mul_wb_prd  <= mul_prd[mul_lat-1];
         mul_wb_opid <= mul_opid[mul_lat-1];
         case (div_st)
            st_idle: if (div_go) begin
               div_st   <= st_busy;
               div_cnt  <= cw'(div_lat - 1);
               div_prd  <= md_prd_in;
               div_opid <= md_opid_in;
            end
            st_busy: begin
               if (div_cnt == '0) div_st <= st_done;
               else               div_cnt <= div_cnt - cw'(1);
            end
            st_done: div_st <= st_idle;
            default: div_st <= st_idle;
         endcase
      end
   end

   // A redirect in the completion cycle kills the wakeup.
   assign bus.md_wb_valid = !bus.redir && (mul_wb_v || (div_st == st_done));
   assign bus.md_wb_prd   = (div_st == st_done) ? div_prd  : mul_wb_prd;
   assign bus.md_wb_opid  = (div_st == st_done) ? div_opid : mul_wb_opid;
endmodule

// File: tb/tb_fu_sched.sv
module tb_fu_sched;
   localparam int iwd     = 4;
   localparam int alu_n   = 1;
   localparam int mul_lat = 3;
   localparam int div_lat = 16;
   localparam int ewd     = alu_n + 3;

   logic clk;
   logic rst;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   fu_sched_if #(.iwd(iwd), .ewd(ewd)) bus ();

   fu_sched #(.iwd(iwd), .alu_n(alu_n), .mul_lat(mul_lat), .div_lat(div_lat)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      int          due;
      logic [15:0] prd;
      logic [15:0] opid;
   } mul_t;

   mul_t           mq[$];
   int             cyc;
   int             div_done;
   int             n_err;
   int             n_chk;
   logic [15:0]    div_prd_m, div_opid_m;
   logic [36:0]    ex_cur [ewd];
   logic [36:0]    ex_nxt [ewd];
   logic [iwd-1:0] e_issue;
   logic [4:0]     e_rdy;
   logic           e_wbv;
   logic [15:0]    e_wbp, e_wbo;
   logic           acc_mul, acc_div;
   logic [15:0]    acc_prd, acc_opid;

   task automatic chk(input string tag, input logic [36:0] got, input logic [36:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic set_lane(input int i, input bit v, input logic [4:0] f,
                           input logic [15:0] prda, input logic [15:0] opid);
      bus.iss_bundle[i] = {v, opid[14:0], f, prda};
   endtask

   task automatic clear_lanes();
      for (int i = 0; i < iwd; i++) bus.iss_bundle[i] = '0;
   endtask

   // Reference: availability from "when did the last div/mul start", then
   // a lane-order walk spending per-class budgets.
   task automatic model_comb();
      bit          div_idle, mul_empty, stop;
      int          bud[3];
      int          md_bud, found, slot;
      logic [36:0] op;
      div_idle  = (div_done < 0) || (cyc > div_done);
      mul_empty = 1'b1;
      foreach (mq[k]) if (mq[k].due > cyc) mul_empty = 1'b0;
      e_rdy    = {div_idle && mul_empty, div_idle, bus.lsu_ready, 2'b11};
      bud[0]   = alu_n;
      bud[1]   = 1;
      bud[2]   = 1;
      md_bud   = 1;
      stop     = rst || bus.redir;
      e_issue  = '0;
      slot     = 0;
      acc_mul  = 1'b0;
      acc_div  = 1'b0;
      acc_prd  = '0;
      acc_opid = '0;
      for (int l = 0; l < ewd; l++) ex_nxt[l] = '0;
      for (int i = 0; i < iwd; i++) begin
         op = bus.iss_bundle[i];
         if (!stop) begin
            found = -1;
            if (op[36]) begin
               for (int c = 0; c < 5; c++)
                  if (found < 0 && op[16+c] && e_rdy[c] && (((c < 3) ? bud[c] : md_bud) > 0))
                     found = c;
            end
            if (found < 0) begin
               stop = 1'b1;
            end else begin
               e_issue[i] = 1'b1;
               if (found == 0) begin
                  ex_nxt[slot] = op;
                  slot++;
                  bud[0]--;
               end else if (found == 1) begin
                  ex_nxt[alu_n] = op;
                  bud[1]--;
               end else if (found == 2) begin
                  ex_nxt[alu_n+1] = op;
                  bud[2]--;
               end else begin
                  ex_nxt[alu_n+2] = op;
                  md_bud--;
                  acc_prd  = op[15:0];
                  acc_opid = op[36:21];
                  if (found == 3) acc_mul = 1'b1;
                  else            acc_div = 1'b1;
               end
            end
         end
      end
      e_wbv = 1'b0;
      e_wbp = '0;
      e_wbo = '0;
      if (!bus.redir) begin
         if (div_done == cyc) begin
            e_wbv = 1'b1;
            e_wbp = div_prd_m;
            e_wbo = div_opid_m;
         end else begin
            foreach (mq[k]) if (mq[k].due == cyc) begin
               e_wbv = 1'b1;
               e_wbp = mq[k].prd;
               e_wbo = mq[k].opid;
            end
         end
      end
   endtask

   task automatic model_seq();
      if (rst || bus.redir) begin
         mq.delete();
         div_done = -1;
         for (int l = 0; l < ewd; l++) ex_cur[l] = '0;
      end else begin
         for (int l = 0; l < ewd; l++) ex_cur[l] = ex_nxt[l];
         while (mq.size() > 0 && mq[0].due <= cyc) void'(mq.pop_front());
         if (acc_mul) mq.push_back('{cyc + 1 + mul_lat, acc_prd, acc_opid});
         if (acc_div) begin
            div_done   = cyc + 1 + div_lat;
            div_prd_m  = acc_prd;
            div_opid_m = acc_opid;
         end
      end
      cyc++;
   endtask

   task automatic check_all();
      for (int l = 0; l < ewd; l++) chk($sformatf("ex_bundle%0d", l), bus.ex_bundle[l], ex_cur[l]);
      chk("issue", bus.issue, e_issue);
      chk("fu_ready", bus.fu_ready, e_rdy);
      chk("md_wb_valid", bus.md_wb_valid, e_wbv);
      if (e_wbv) begin
         chk("md_wb_prd", bus.md_wb_prd, e_wbp);
         chk("md_wb_opid", bus.md_wb_opid, e_wbo);
      end
   endtask

   task automatic settle(input bit do_chk);
      @(negedge clk);
      model_comb();
      if (do_chk) check_all();
   endtask

   task automatic advance();
      @(posedge clk);
      model_seq();
      #1;
   endtask

   task automatic idle(input int n);
      clear_lanes();
      for (int k = 0; k < n; k++) begin
         settle(1'b1);
         advance();
      end
   endtask

   initial begin
      logic [4:0] f;
      int         k;
      n_err    = 0;
      n_chk    = 0;
      cyc      = 0;
      div_done = -1;
      for (int l = 0; l < ewd; l++) ex_cur[l] = '0;
      rst           = 1'b1;
      bus.redir     = 1'b0;
      bus.lsu_ready = 1'b1;
      clear_lanes();
      settle(1'b0);
      advance();
      settle(1'b0);
      advance();
      rst = 1'b0;

      // T1 reset state
      settle(1'b1);
      chk("t1_fu_ready", bus.fu_ready, 5'b11111);
      chk("t1_issue", bus.issue, 4'b0000);
      advance();

      // T2 two ALUs with one ALU lane, BR behind them blocked by prefix rule
      set_lane(0, 1'b1, 5'b00001, 16'h0011, 16'h0101);
      set_lane(1, 1'b1, 5'b00001, 16'h0012, 16'h0102);
      set_lane(2, 1'b1, 5'b00010, 16'h0013, 16'h0103);
      set_lane(3, 1'b0, 5'b00001, 16'h0014, 16'h0104);
      settle(1'b1);
      chk("t2_issue", bus.issue, 4'b0001);
      advance();
      clear_lanes();
      settle(1'b1);
      chk("t2_ex_alu", bus.ex_bundle[0], {1'b1, 15'h0101, 5'b00001, 16'h0011});
      chk("t2_ex_br", bus.ex_bundle[1], 37'h0);
      advance();

      // T3 one of each class; mul result at t+4
      set_lane(0, 1'b1, 5'b00001, 16'h0031, 16'h0301);
      set_lane(1, 1'b1, 5'b00010, 16'h0032, 16'h0302);
      set_lane(2, 1'b1, 5'b00100, 16'h0034, 16'h0304);
      set_lane(3, 1'b1, 5'b01000, 16'h0033, 16'h0303);
      settle(1'b1);
      chk("t3_issue", bus.issue, 4'b1111);
      advance();
      clear_lanes();
      for (int t = 1; t <= 4; t++) begin
         settle(1'b1);
         if (t == 1) chk("t3_ex_md", bus.ex_bundle[3], {1'b1, 15'h0303, 5'b01000, 16'h0033});
         if (t == 4) begin
            chk("t3_wb_valid", bus.md_wb_valid, 1'b1);
            chk("t3_wb_prd", bus.md_wb_prd, 16'h0033);
         end
         advance();
      end

      // T4 divide: busy 16 cycles, result at t+17, free at t+18
      set_lane(0, 1'b1, 5'b10000, 16'h0021, 16'h0421);
      settle(1'b1);
      chk("t4_issue", bus.issue, 4'b0001);
      advance();
      clear_lanes();
      for (int t = 1; t <= 18; t++) begin
         settle(1'b1);
         if (t <= 16) chk("t4_busy_rdy", bus.fu_ready[4:3], 2'b00);
         if (t == 17) begin
            chk("t4_wb_valid", bus.md_wb_valid, 1'b1);
            chk("t4_wb_prd", bus.md_wb_prd, 16'h0021);
         end
         if (t == 18) chk("t4_free_rdy", bus.fu_ready[4:3], 2'b11);
         advance();
      end

      // T5 LSU blocked then released within the same cycle
      bus.lsu_ready = 1'b0;
      set_lane(0, 1'b1, 5'b00100, 16'h0051, 16'h0501);
      set_lane(1, 1'b1, 5'b00001, 16'h0052, 16'h0502);
      settle(1'b1);
      chk("t5_blocked", bus.issue, 4'b0000);
      bus.lsu_ready = 1'b1;
      #1;
      model_comb();
      check_all();
      chk("t5_released", bus.issue, 4'b0011);
      advance();

      // T6 redirect while divide busy with cnt=5
      set_lane(0, 1'b1, 5'b10000, 16'h0061, 16'h0601);
      set_lane(1, 1'b0, 5'b00001, 16'h0000, 16'h0000);
      settle(1'b1);
      advance();
      idle(10);
      bus.redir = 1'b1;
      set_lane(0, 1'b1, 5'b00001, 16'h0062, 16'h0602);
      settle(1'b1);
      chk("t6_redir_issue", bus.issue, 4'b0000);
      advance();
      bus.redir = 1'b0;
      clear_lanes();
      settle(1'b1);
      chk("t6_div_idle", bus.fu_ready[4:3], 2'b11);
      chk("t6_ex_clear", bus.ex_bundle[0], 37'h0);
      advance();
      idle(8);

      // redirect in the divide completion cycle suppresses the wakeup
      set_lane(0, 1'b1, 5'b10000, 16'h0071, 16'h0701);
      settle(1'b1);
      advance();
      idle(16);
      bus.redir = 1'b1;
      settle(1'b1);
      chk("done_redir_wb", bus.md_wb_valid, 1'b0);
      advance();
      bus.redir = 1'b0;
      idle(2);

      // randomized traffic against the reference model
      for (int n = 0; n < 400; n++) begin
         bus.redir     = ($urandom_range(0, 24) == 0);
         bus.lsu_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < iwd; i++) begin
            k = $urandom_range(0, 6);
            f = (k < 5) ? 5'(1 << k) : 5'($urandom);
            set_lane(i, $urandom_range(0, 4) != 0, f, 16'($urandom), 16'($urandom));
         end
         settle(1'b1);
         advance();
      end
      bus.redir = 1'b0;
      idle(20);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
